// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_ctrl_pkg : opcode, state and mux-select encodings shared by the
//                       multicycle control FSM and the datapath decoders.
// Rev 1.0
// ---------------------------------------------------------------------------
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4,
    ST_HLT = 3'd5
  } state_e;

  localparam logic [3:0] OPC_R    = 4'b0000;
  localparam logic [3:0] OPC_ADDI = 4'b0001;
  localparam logic [3:0] OPC_LW   = 4'b0010;
  localparam logic [3:0] OPC_SW   = 4'b0011;
  localparam logic [3:0] OPC_BEQ  = 4'b0100;
  localparam logic [3:0] OPC_J    = 4'b0101;
  localparam logic [3:0] OPC_HALT = 4'b1111;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    OPK_R,
    OPK_ADDI,
    OPK_LW,
    OPK_SW,
    OPK_BEQ,
    OPK_J,
    OPK_HALT,
    OPK_ILLEGAL
  } opkind_e;

  // Opcodes are zero-extended to 8 bits so any set high bit reads as illegal.
  function automatic opkind_e classify(input logic [7:0] op);
    opkind_e k;
    k = OPK_ILLEGAL;
    if (op[7:4] == 4'b0000) begin
      case (op[3:0])
        OPC_R:    k = OPK_R;
        OPC_ADDI: k = OPK_ADDI;
        OPC_LW:   k = OPK_LW;
        OPC_SW:   k = OPK_SW;
        OPC_BEQ:  k = OPK_BEQ;
        OPC_J:    k = OPK_J;
        OPC_HALT: k = OPK_HALT;
        default:  k = OPK_ILLEGAL;
      endcase
    end
    return k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_out_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ctrl_out_decode : combinational State/Op/Zero/MemRdy -> control outputs,
//                   with every output forced low while Clrn is asserted.
// Rev 1.0
// ---------------------------------------------------------------------------
module ctrl_out_decode
  import multicycle_ctrl_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic            Clrn,
  input  state_e          State,
  input  logic [OP_W-1:0] Op,
  input  logic            Zero,
  input  logic            MemRdy,
  output logic            PCWr,
  output logic            IRWr,
  output logic            RegWr,
  output logic            MemRd,
  output logic            MemWr,
  output logic            IorD,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [1:0]      PCSrc,
  output logic            RegDst,
  output logic            MemtoReg,
  output logic            Halted,
  output logic            Illegal
);

  opkind_e w_kind;
  assign w_kind = classify(8'(Op));

  always_comb begin
    PCWr     = 1'b0;
    IRWr     = 1'b0;
    RegWr    = 1'b0;
    MemRd    = 1'b0;
    MemWr    = 1'b0;
    IorD     = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_RT;
    ALUOp    = ALUOP_ADD;
    PCSrc    = PCSRC_ALU;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    Halted   = 1'b0;
    Illegal  = 1'b0;
    if (Clrn) begin
      case (State)
        ST_IF: begin
          MemRd   = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWr    = MemRdy;
          PCWr    = MemRdy;
        end
        ST_ID: begin
          // Branch target is precomputed into ALUOut for the following EX.
          ALUSrcB = SRCB_IMM_SH2;
          if (w_kind == OPK_J) begin
            PCWr  = 1'b1;
            PCSrc = PCSRC_JUMP;
          end
          Illegal = (w_kind == OPK_ILLEGAL);
        end
        ST_EX: begin
          ALUSrcA = 1'b1;
          case (w_kind)
            OPK_R: begin
              ALUSrcB = SRCB_RT;
              ALUOp   = ALUOP_FUNCT;
            end
            OPK_ADDI, OPK_LW, OPK_SW: begin
              ALUSrcB = SRCB_IMM;
            end
            OPK_BEQ: begin
              ALUOp = ALUOP_SUB;
              PCSrc = PCSRC_ALUOUT;
              PCWr  = Zero;
            end
            default: ALUSrcA = 1'b0;
          endcase
        end
        ST_MEM: begin
          IorD  = 1'b1;
          MemRd = (w_kind == OPK_LW);
          MemWr = (w_kind == OPK_SW);
        end
        ST_WB: begin
          RegWr    = 1'b1;
          RegDst   = (w_kind == OPK_R);
          MemtoReg = (w_kind == OPK_LW);
        end
        ST_HLT: Halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_ctrl : multicycle CPU control FSM; state register and next-state
//                   logic, outputs decoded by ctrl_out_decode.
// Rev 1.0
// ---------------------------------------------------------------------------
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int OP_W = 4,
  parameter int ST_W = 3
) (
  input  logic            Clk,
  input  logic            Clrn,
  input  logic [OP_W-1:0] Op,
  input  logic            Zero,
  input  logic            MemRdy,
  output logic            PCWr,
  output logic            IRWr,
  output logic            RegWr,
  output logic            MemRd,
  output logic            MemWr,
  output logic            IorD,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [1:0]      PCSrc,
  output logic            RegDst,
  output logic            MemtoReg,
  output logic            Halted,
  output logic            Illegal,
  output logic [ST_W-1:0] State
);

  state_e  state_q;
  state_e  state_d;
  opkind_e w_kind;

  assign w_kind = classify(8'(Op));

  always_comb begin
    state_d = ST_IF;
    case (state_q)
      ST_IF:  state_d = MemRdy ? ST_ID : ST_IF;
      ST_ID: begin
        case (w_kind)
          OPK_HALT:           state_d = ST_HLT;
          OPK_J, OPK_ILLEGAL: state_d = ST_IF;
          default:            state_d = ST_EX;
        endcase
      end
      ST_EX: begin
        case (w_kind)
          OPK_R, OPK_ADDI: state_d = ST_WB;
          OPK_LW, OPK_SW:  state_d = ST_MEM;
          default:         state_d = ST_IF;
        endcase
      end
      ST_MEM: begin
        if (!MemRdy)
          state_d = ST_MEM;
        else if (w_kind == OPK_LW)
          state_d = ST_WB;
        else
          state_d = ST_IF;
      end
      ST_WB:  state_d = ST_IF;
      ST_HLT: state_d = ST_HLT;
      // Unreachable codes recover to fetch.
      default: state_d = ST_IF;
    endcase
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn)
      state_q <= ST_IF;
    else
      state_q <= state_d;
  end

  assign State = ST_W'(state_q);

  ctrl_out_decode #(
    .OP_W (OP_W)
  ) u_out_decode (
    .Clrn     (Clrn),
    .State    (state_q),
    .Op       (Op),
    .Zero     (Zero),
    .MemRdy   (MemRdy),
    .PCWr     (PCWr),
    .IRWr     (IRWr),
    .RegWr    (RegWr),
    .MemRd    (MemRd),
    .MemWr    (MemWr),
    .IorD     (IorD),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .PCSrc    (PCSrc),
    .RegDst   (RegDst),
    .MemtoReg (MemtoReg),
    .Halted   (Halted),
    .Illegal  (Illegal)
  );

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl : instruction-level reference model feeding a scoreboard
//                      that is drained once per cycle by a monitor.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       pcwr, irwr, regwr, memrd, memwr, iord, srca;
    logic [1:0] srcb, aluop, pcsrc;
    logic       regdst, memtoreg, halted, illegal;
  } out_t;

  typedef struct packed {
    logic       rstn;
    logic       rdy;
    logic       zero;
    logic [3:0] op;
    out_t       exp;
  } cyc_t;

  logic       clk = 1'b0;
  logic       clrn;
  logic [3:0] op;
  logic       zero;
  logic       rdy;
  logic       pcwr, irwr, regwr, memrd, memwr, iord, srca;
  logic [1:0] srcb, aluop, pcsrc;
  logic       regdst, memtoreg, halted, illegal;
  logic [2:0] st;

  cyc_t plan[$];
  out_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.OP_W(4), .ST_W(3)) dut (
    .Clk(clk), .Clrn(clrn), .Op(op), .Zero(zero), .MemRdy(rdy),
    .PCWr(pcwr), .IRWr(irwr), .RegWr(regwr), .MemRd(memrd), .MemWr(memwr),
    .IorD(iord), .ALUSrcA(srca), .ALUSrcB(srcb), .ALUOp(aluop), .PCSrc(pcsrc),
    .RegDst(regdst), .MemtoReg(memtoreg), .Halted(halted), .Illegal(illegal),
    .State(st)
  );

  // Expected outputs per instruction phase.
  function automatic out_t ph_fetch(logic r);
    out_t o = '0;
    o.st = 3'd0; o.memrd = 1'b1; o.srcb = 2'b01; o.pcwr = r; o.irwr = r;
    return o;
  endfunction

  function automatic out_t ph_decode(logic [3:0] opc);
    out_t o = '0;
    o.st = 3'd1; o.srcb = 2'b11;
    if (opc == 4'd5) begin o.pcwr = 1'b1; o.pcsrc = 2'b10; end
    o.illegal = !(opc <= 4'd5 || opc == 4'd15);
    return o;
  endfunction

  function automatic out_t ph_exec(logic [3:0] opc, logic z);
    out_t o = '0;
    o.st = 3'd2; o.srca = 1'b1;
    if (opc == 4'd0) o.aluop = 2'b10;
    else if (opc == 4'd4) begin o.aluop = 2'b01; o.pcsrc = 2'b01; o.pcwr = z; end
    else o.srcb = 2'b10;
    return o;
  endfunction

  function automatic out_t ph_mem(logic [3:0] opc);
    out_t o = '0;
    o.st = 3'd3; o.iord = 1'b1;
    o.memrd = (opc == 4'd2); o.memwr = (opc == 4'd3);
    return o;
  endfunction

  function automatic out_t ph_wb(logic [3:0] opc);
    out_t o = '0;
    o.st = 3'd4; o.regwr = 1'b1;
    o.regdst = (opc == 4'd0); o.memtoreg = (opc == 4'd2);
    return o;
  endfunction

  function automatic out_t ph_halt();
    out_t o = '0;
    o.st = 3'd5; o.halted = 1'b1;
    return o;
  endfunction

  task automatic add(input logic rn, input logic r, input logic z,
                     input logic [3:0] o, input out_t e);
    cyc_t c;
    c.rstn = rn; c.rdy = r; c.zero = z; c.op = o; c.exp = e;
    plan.push_back(c);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] rop();
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic plan_reset(input int n);
    for (int i = 0; i < n; i++) add(1'b0, rbit(), rbit(), rop(), '0);
  endtask

  // Builds the full cycle-by-cycle expectation for one instruction.
  task automatic plan_instr(input logic [3:0] opc, input int nfs, input int nms,
                            input logic z, input int nhlt);
    for (int i = 0; i < nfs; i++) add(1'b1, 1'b0, rbit(), rop(), ph_fetch(1'b0));
    add(1'b1, 1'b1, rbit(), rop(), ph_fetch(1'b1));
    add(1'b1, rbit(), rbit(), opc, ph_decode(opc));
    case (opc)
      4'd0, 4'd1: begin
        add(1'b1, rbit(), rbit(), opc, ph_exec(opc, 1'b0));
        add(1'b1, rbit(), rbit(), opc, ph_wb(opc));
      end
      4'd2, 4'd3: begin
        add(1'b1, rbit(), rbit(), opc, ph_exec(opc, 1'b0));
        for (int i = 0; i < nms; i++) add(1'b1, 1'b0, rbit(), opc, ph_mem(opc));
        add(1'b1, 1'b1, rbit(), opc, ph_mem(opc));
        if (opc == 4'd2) add(1'b1, rbit(), rbit(), opc, ph_wb(opc));
      end
      4'd4: add(1'b1, rbit(), z, opc, ph_exec(opc, z));
      4'd15: for (int i = 0; i < nhlt; i++) add(1'b1, rbit(), rbit(), rop(), ph_halt());
      default: ;
    endcase
  endtask

  task automatic emit(input int limit);
    cyc_t c;
    int   n;
    n = (limit < plan.size()) ? limit : plan.size();
    for (int i = 0; i < n; i++) begin
      c = plan[i];
      @(posedge clk);
      #1;
      clrn = c.rstn; rdy = c.rdy; zero = c.zero; op = c.op;
      sb.push_back(c.exp);
    end
    plan.delete();
  endtask

  task automatic emit_all();
    emit(plan.size());
  endtask

  // Monitor: one expected record is consumed per cycle, mid-cycle.
  initial begin
    out_t e, a;
    forever begin
      @(negedge clk);
      cycle++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = {st, pcwr, irwr, regwr, memrd, memwr, iord, srca,
             srcb, aluop, pcsrc, regdst, memtoreg, halted, illegal};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs cycle %0d: got %05h (state %0d) expected %05h (state %0d)",
                   cycle, a, a.st, e, e.st);
        end
      end
    end
  end

  initial begin
    logic [3:0] opc;
    int         k;
    clrn = 1'b0; rdy = 1'b1; zero = 1'b0; op = 4'd0;

    plan_reset(3);
    plan_instr(4'd0, 0, 0, 1'b0, 0);        // R
    plan_instr(4'd2, 0, 2, 1'b0, 0);        // LW with MEM stall
    plan_instr(4'd4, 0, 0, 1'b1, 0);        // BEQ taken
    plan_instr(4'd4, 0, 0, 1'b0, 0);        // BEQ not taken
    plan_instr(4'd1, 0, 0, 1'b0, 0);        // ADDI
    plan_instr(4'd3, 0, 1, 1'b0, 0);        // SW with MEM stall
    plan_instr(4'd5, 0, 0, 1'b0, 0);        // J
    plan_instr(4'd0, 4, 0, 1'b0, 0);        // fetch stall
    plan_instr(4'd9, 0, 0, 1'b0, 0);        // illegal
    plan_instr(4'd15, 0, 0, 1'b0, 6);       // HALT
    plan_reset(2);
    emit_all();

    for (int n = 0; n < 150; n++) begin
      opc = rop();
      plan_instr(opc, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                 rbit(), int'($urandom_range(1, 4)));
      if (opc == 4'd15) begin
        plan_reset(int'($urandom_range(1, 2)));
        emit_all();
      end else if ($urandom_range(0, 7) == 0) begin
        k = int'($urandom_range(1, plan.size() - 1));
        emit(k);
        plan_reset(int'($urandom_range(1, 2)));
        emit_all();
      end else begin
        emit_all();
      end
    end

    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
